// File: rtl/div_unit_pkg.sv
// Shared encodings and constants for the multi-cycle divider.
// State codes match the pipeline controller's view of the divider.
package div_unit_pkg;

    localparam int DIV_DATA_W = 32;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } div_state_t;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division iteration: trial-subtract the divisor from the partial remainder.
// Combinational, no backpressure.
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_o
);

    logic [DATA_W:0] diff;

    // rem_i < 2*divisor, so the difference always fits in DATA_W+1 signed bits
    assign diff  = rem_i - {1'b0, divisor_i};
    assign q_o   = ~diff[DATA_W];
    assign rem_o = q_o ? diff[DATA_W-1:0] : rem_i[DATA_W-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider producing {remainder, quotient}.
// Latency: 34 edges incl. accept (2 for divide by zero); annul_i aborts, result held while start_i stays high.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

    div_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*DATA_W-1:0]     work_q, work_d;     // {partial remainder, dividend/quotient}
    logic [DATA_W-1:0]       divisor_q, divisor_d;
    logic                    signed_q, signed_d;
    logic                    sign1_q, sign1_d;
    logic                    sign2_q, sign2_d;
    logic [2*DATA_W-1:0]     result_d;
    logic                    ready_d;

    logic [DATA_W-1:0]       mag1, mag2;
    logic [DATA_W-1:0]       step_rem;
    logic                    step_q;
    logic [DATA_W-1:0]       quot_fix, rem_fix;

    assign mag1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign mag2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (work_q[2*DATA_W-1:DATA_W-1]),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    assign quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    assign rem_fix  = (signed_q && sign1_q) ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_o;
        ready_d   = ready_o;

        if (annul_i) begin
            state_d  = FREE;
            cnt_d    = '0;
            result_d = '0;
            ready_d  = DivResultNotReady;
        end else begin
            case (state_q)
                FREE: begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    if (start_i == DivStart) begin
                        if (opdata2_i == '0) begin
                            state_d = BYZERO;
                        end else begin
                            state_d   = ON;
                            cnt_d     = '0;
                            work_d    = {{DATA_W{1'b0}}, mag1};
                            divisor_d = mag2;
                            signed_d  = signed_div_i;
                            sign1_d   = opdata1_i[DATA_W-1];
                            sign2_d   = opdata2_i[DATA_W-1];
                        end
                    end
                end
                BYZERO: begin
                    state_d  = END;
                    result_d = '0;
                    ready_d  = DivResultReady;
                end
                ON: begin
                    if (cnt_q != CNT_LAST) begin
                        work_d = {step_rem, work_q[DATA_W-2:0], step_q};
                        cnt_d  = cnt_q + 1'b1;
                    end else begin
                        state_d  = END;
                        result_d = {rem_fix, quot_fix};
                        ready_d  = DivResultReady;
                    end
                end
                END: begin
                    if (start_i == DivStop) begin
                        state_d  = FREE;
                        result_d = '0;
                        ready_d  = DivResultNotReady;
                    end
                end
                default: state_d = FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_o  <= result_d;
            ready_o   <= ready_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: fixed vector table, randomized operands against an arithmetic model,
// and hand-written annul / reset / hold sequences.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int tests = 0;
    int fails = 0;

    div_unit #(.DATA_W(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: plain integer division with truncation toward zero
    function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issues a request, scrambles operands after accept, returns result and edges past accept.
    task automatic run_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                           output logic [63:0] res, output int edges);
        @(negedge clk);
        signed_div = s;
        op1 = a;
        op2 = b;
        start = 1'b1;
        @(negedge clk);
        signed_div = ~s;
        op1 = $urandom;
        op2 = $urandom;
        edges = 0;
        while (ready !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        res = result;
    endtask

    task automatic drop_start(input string name);
        start = 1'b0;
        @(negedge clk);
        check({name, "_ready_low"}, 64'(ready), 64'd0);
        check({name, "_result_clr"}, result, 64'd0);
    endtask

    vec_t        vecs[8];
    logic [63:0] res, held;
    int          edges;
    bit          s;
    logic [31:0] a, b;
    bit          saw_ready;

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_state", 64'(dut.state_q), 64'(FREE));
        rst = 1'b0;

        vecs[0] = '{0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 33};
        vecs[1] = '{1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33};
        vecs[2] = '{1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 33};
        vecs[3] = '{0, 32'd1234,       32'd0,          64'd0,                        1};
        vecs[4] = '{1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 33};
        vecs[5] = '{0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 33};
        vecs[6] = '{0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h00000000, 32'h00000001}, 33};
        vecs[7] = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'h0000000E}, 33};

        foreach (vecs[i]) begin
            run_div(vecs[i].s, vecs[i].a, vecs[i].b, res, edges);
            check($sformatf("vec%0d_latency", i), 64'(edges), 64'(vecs[i].lat));
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            drop_start($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_div(s, a, b, res, edges);
            check($sformatf("rand%0d_latency", i), 64'(edges), (b == 0) ? 64'd1 : 64'd33);
            check($sformatf("rand%0d_result", i), res, model(s, a, b));
            start = 1'b0;
            @(negedge clk);
        end

        // Annul at iteration 10: abort and never produce a result
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready", 64'(ready), 64'd0);
        check("annul_result", result, 64'd0);
        check("annul_state", 64'(dut.state_q), 64'(FREE));
        saw_ready = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready === 1'b1) saw_ready = 1'b1;
        end
        check("annul_no_ready", 64'(saw_ready), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, res, edges);
        check("post_annul_latency", 64'(edges), 64'd33);
        check("post_annul_result", res, {32'd0, 32'd3});
        drop_start("post_annul");

        // Annul on the accept edge: request must not be taken
        @(negedge clk);
        op1 = 32'd50; op2 = 32'd5; start = 1'b1; annul = 1'b1;
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        check("annul_accept_state", 64'(dut.state_q), 64'(FREE));
        @(negedge clk);

        // Reset mid-divide
        op1 = 32'd77; op2 = 32'd4; start = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_state", 64'(dut.state_q), 64'(FREE));

        // Result held stable while start stays high in END
        run_div(1'b1, 32'hFFFFFF00, 32'd16, res, edges);
        check("hold_first", res, {32'd0, 32'hFFFFFFF0});
        held = res;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold%0d_result", i), result, held);
            check($sformatf("hold%0d_ready", i), 64'(ready), 64'd1);
        end
        drop_start("hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
